// File: rtl/sample_fifo_sc.sv
// sample_fifo_sc: single-clock show-ahead FIFO for ADC sample words.
// Head word is read asynchronously from a register array; status flags are
// registered from the next-state fill count. Sticky overflow/underflow flags
// and a high-water mark support buffer-sizing diagnostics.
module sample_fifo_sc #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 13,
  parameter int AF_THRESH  = (1 << ADDR_WIDTH) - 16,
  parameter int AE_THRESH  = 16
) (
  input  logic                  clock,
  input  logic                  nReset,
  input  logic                  sclr,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  wrreq,
  input  logic                  rdreq,
  output logic [DATA_WIDTH-1:0] q,
  output logic                  empty,
  output logic                  full,
  output logic                  almost_empty,
  output logic                  almost_full,
  output logic [ADDR_WIDTH:0]   usedw,
  output logic [ADDR_WIDTH:0]   hwm,
  input  logic                  clr_hwm,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AF_W    = (ADDR_WIDTH+1)'(AF_THRESH);
  localparam logic [ADDR_WIDTH:0] AE_W    = (ADDR_WIDTH+1)'(AE_THRESH);

  // Thresholds must be ordered and reachable, otherwise the flags are meaningless.
  if (!((AE_THRESH >= 0) && (AE_THRESH < AF_THRESH) && (AF_THRESH <= DEPTH))) begin : g_bad_thresh
    $error("sample_fifo_sc: need 0 <= AE_THRESH < AF_THRESH <= DEPTH");
  end

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   usedw_q, usedw_d;
  logic [ADDR_WIDTH:0]   hwm_q, hwm_d;
  logic                  empty_q, empty_d;
  logic                  full_q, full_d;
  logic                  ae_q, ae_d;
  logic                  af_q, af_d;
  logic                  ovf_q, ovf_d;
  logic                  udf_q, udf_d;

  logic rd_ok;
  logic wr_ok;

  // Accept decisions are made on the pre-edge state; a full FIFO takes a
  // write only when a read frees a slot in the same cycle.
  always_comb begin
    rd_ok = rdreq & ~empty_q;
    wr_ok = wrreq & (~full_q | rd_ok);
  end

  // Next-state computation for pointers, count, flags and diagnostics.
  always_comb begin
    // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    usedw_d  = usedw_q;
    hwm_d    = hwm_q;
    ovf_d    = ovf_q;
    udf_d    = udf_q;
    empty_d  = empty_q;
    full_d   = full_q;
    ae_d     = ae_q;
    af_d     = af_q;

    if (sclr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      usedw_d  = '0;
      hwm_d    = '0;
      ovf_d    = 1'b0;
      udf_d    = 1'b0;
      empty_d  = 1'b1;
      full_d   = 1'b0;
      ae_d     = 1'b1;
      af_d     = 1'b0;
    end else begin
      if (wr_ok) wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
      if (rd_ok) rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);
      usedw_d = usedw_q + (ADDR_WIDTH+1)'(wr_ok) - (ADDR_WIDTH+1)'(rd_ok);

      if (wrreq && !wr_ok) ovf_d = 1'b1;
      if (rdreq && !rd_ok) udf_d = 1'b1;

      if (clr_hwm)               hwm_d = usedw_d;
      else if (usedw_d > hwm_q)  hwm_d = usedw_d;

      // Flags come from the next count so they are valid right after the edge.
      empty_d = (usedw_d == '0);
      full_d  = (usedw_d == DEPTH_W);
      ae_d    = (usedw_d <= AE_W);
      af_d    = (usedw_d >= AF_W);
    end
  end

  // Control state register with asynchronous reset.
  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      usedw_q  <= '0;
      hwm_q    <= '0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
      ae_q     <= 1'b1;
      af_q     <= 1'b0;
    end else begin
      // NOTE: sequential state always uses non-blocking assignment to avoid simulation races.
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      usedw_q  <= usedw_d;
      hwm_q    <= hwm_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
      empty_q  <= empty_d;
      full_q   <= full_d;
      ae_q     <= ae_d;
      af_q     <= af_d;
    end
  end

  // Storage array write port.
  always_ff @(posedge clock) begin
    // NOTE: the array is deliberately not reset; contents are only observable through valid pointers.
    if (wr_ok && !sclr) mem[wr_ptr_q] <= data;
  end

  // Show-ahead output: the head word is visible without a read request.
  always_comb begin
    q            = mem[rd_ptr_q];
    empty        = empty_q;
    full         = full_q;
    almost_empty = ae_q;
    almost_full  = af_q;
    usedw        = usedw_q;
    hwm          = hwm_q;
    overflow     = ovf_q;
    underflow    = udf_q;
  end

endmodule

// File: tb/tb_sample_fifo_sc.sv
// tb_sample_fifo_sc: directed self-checking bench for sample_fifo_sc
// (DATA_WIDTH=16, ADDR_WIDTH=4, AF_THRESH=12, AE_THRESH=2).
module tb_sample_fifo_sc;

  localparam int DW = 16;
  localparam int AW = 4;

  logic          clock = 1'b0;
  logic          nReset;
  logic          sclr;
  logic [DW-1:0] data;
  logic          wrreq;
  logic          rdreq;
  logic [DW-1:0] q;
  logic          empty;
  logic          full;
  logic          almost_empty;
  logic          almost_full;
  logic [AW:0]   usedw;
  logic [AW:0]   hwm;
  logic          clr_hwm;
  logic          overflow;
  logic          underflow;

  int total = 0;
  int bad   = 0;

  sample_fifo_sc #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .AF_THRESH (12),
    .AE_THRESH (2)
  ) dut (
    .clock       (clock),
    .nReset      (nReset),
    .sclr        (sclr),
    .data        (data),
    .wrreq       (wrreq),
    .rdreq       (rdreq),
    .q           (q),
    .empty       (empty),
    .full        (full),
    .almost_empty(almost_empty),
    .almost_full (almost_full),
    .usedw       (usedw),
    .hwm         (hwm),
    .clr_hwm     (clr_hwm),
    .overflow    (overflow),
    .underflow   (underflow)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    sclr = 0; wrreq = 0; rdreq = 0; clr_hwm = 0;
  endtask

  task automatic push(input logic [DW-1:0] d);
    wrreq = 1; data = d; step(); wrreq = 0;
  endtask

  task automatic pop();
    rdreq = 1; step(); rdreq = 0;
  endtask

  task automatic pulse_sclr();
    sclr = 1; step(); sclr = 0;
  endtask

  initial begin
    nReset = 0; data = '0;
    idle();

    // 1: reset, single write, single read
    repeat (5) step();
    nReset = 1;
    step();
    check("rst_empty", 32'(empty), 1);
    check("rst_usedw", 32'(usedw), 0);
    check("rst_ae", 32'(almost_empty), 1);
    check("rst_full", 32'(full), 0);
    check("rst_af", 32'(almost_full), 0);
    check("rst_ovf", 32'(overflow), 0);
    check("rst_udf", 32'(underflow), 0);
    check("rst_hwm", 32'(hwm), 0);
    push(16'hA5A5);
    check("t1_empty", 32'(empty), 0);
    check("t1_q", 32'(q), 32'hA5A5);
    check("t1_usedw", 32'(usedw), 1);
    check("t1_ae", 32'(almost_empty), 1);
    pop();
    check("t1_rd_empty", 32'(empty), 1);
    check("t1_rd_usedw", 32'(usedw), 0);

    // 2: fill to full, overflow, drain with pointer wrap
    for (int i = 0; i < 16; i++) begin
      push(DW'(i));
      check("t2_usedw", 32'(usedw), 32'(i + 1));
      check("t2_af", 32'(almost_full), 32'((i + 1) >= 12));
      check("t2_full", 32'(full), 32'((i + 1) == 16));
    end
    push(16'hDEAD);
    check("t2_ovf", 32'(overflow), 1);
    check("t2_usedw_hold", 32'(usedw), 16);
    check("t2_full_hold", 32'(full), 1);
    check("t2_hwm", 32'(hwm), 16);
    for (int i = 0; i < 16; i++) begin
      check("t2_q", 32'(q), 32'(i));
      pop();
    end
    check("t2_empty", 32'(empty), 1);
    check("t2_usedw0", 32'(usedw), 0);

    // 3: write+read on a full FIFO
    pulse_sclr();
    for (int i = 0; i < 16; i++) push(DW'(i));
    check("t3_full", 32'(full), 1);
    check("t3_head", 32'(q), 0);
    wrreq = 1; rdreq = 1; data = 16'h0100;
    step();
    idle();
    check("t3_usedw", 32'(usedw), 16);
    check("t3_ovf", 32'(overflow), 0);
    check("t3_full2", 32'(full), 1);
    for (int i = 1; i < 16; i++) begin
      check("t3_q", 32'(q), 32'(i));
      pop();
    end
    check("t3_q_last", 32'(q), 32'h0100);
    pop();
    check("t3_empty", 32'(empty), 1);

    // 4: write+read on an empty FIFO, then synchronous clear
    wrreq = 1; rdreq = 1; data = 16'h0042;
    step();
    idle();
    check("t4_udf", 32'(underflow), 1);
    check("t4_usedw", 32'(usedw), 1);
    check("t4_q", 32'(q), 32'h0042);
    check("t4_empty", 32'(empty), 0);
    pulse_sclr();
    check("t4_clr_usedw", 32'(usedw), 0);
    check("t4_clr_empty", 32'(empty), 1);
    check("t4_clr_udf", 32'(underflow), 0);
    check("t4_clr_ovf", 32'(overflow), 0);
    check("t4_clr_hwm", 32'(hwm), 0);

    // 5: high-water mark and almost_empty boundary
    for (int i = 0; i < 10; i++) push(DW'(16'h0200 + i));
    check("t5_hwm10", 32'(hwm), 10);
    for (int i = 0; i < 7; i++) begin
      check("t5_q", 32'(q), 32'(16'h0200 + i));
      pop();
      check("t5_ae", 32'(almost_empty), 32'((10 - (i + 1)) <= 2));
    end
    check("t5_usedw3", 32'(usedw), 3);
    check("t5_hwm_keep", 32'(hwm), 10);
    clr_hwm = 1; step(); clr_hwm = 0;
    check("t5_hwm3", 32'(hwm), 3);
    push(16'h0300);
    check("t5_hwm4", 32'(hwm), 4);
    pop();
    pop();
    check("t5_usedw2", 32'(usedw), 2);
    check("t5_ae_at2", 32'(almost_empty), 1);
    push(16'h0301);
    check("t5_usedw3b", 32'(usedw), 3);
    check("t5_ae_at3", 32'(almost_empty), 0);
    check("t5_hwm_still4", 32'(hwm), 4);

    // 6: asynchronous reset mid-stream
    for (int i = 0; i < 8; i++) push(DW'(16'h0400 + i));
    check("t6_usedw11", 32'(usedw), 11);
    nReset = 0;
    #1;
    check("t6_rst_usedw", 32'(usedw), 0);
    check("t6_rst_empty", 32'(empty), 1);
    check("t6_rst_ae", 32'(almost_empty), 1);
    check("t6_rst_hwm", 32'(hwm), 0);
    check("t6_rst_af", 32'(almost_full), 0);
    step();
    nReset = 1;
    step();
    push(16'h1234);
    check("t6_q", 32'(q), 32'h1234);
    check("t6_usedw1", 32'(usedw), 1);
    pop();
    check("t6_empty", 32'(empty), 1);
    check("t6_udf", 32'(underflow), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sample_fifo_sc.md
Name: sample_fifo_sc

Overview:
- Parametrised single-clock show-ahead FIFO that buffers ADC sample words between the sample path and the USB/GPIF transfer logic.
- Successor to the fixed 16-bit / 14-bit-counter dual-clock IP FIFO, which it replaces where both sides share one clock.
- Generalised width and depth; programmable almost-full and almost-empty thresholds.
- Adds behaviour the IP FIFO lacks: sticky overflow/underflow flags, a non-wrapping fill count, and a high-water-mark register for buffer-sizing diagnostics.

Parameters:
- DATA_WIDTH, 16: bits per word.
- ADDR_WIDTH, 13: log2 of depth; DEPTH = 2^ADDR_WIDTH words.
- AF_THRESH, 2^ADDR_WIDTH-16: almost_full asserts when usedw >= AF_THRESH.
- AE_THRESH, 16: almost_empty asserts when usedw <= AE_THRESH.

Ports:
- clock  in  1  system clock; all logic on rising edge.
- nReset  in  1  asynchronous active-low reset.
- sclr  in  1  synchronous clear: empties FIFO, clears sticky flags and hwm.
- data  in  DATA_WIDTH  write data.
- wrreq  in  1  write request.
- rdreq  in  1  read acknowledge; q advances after the edge.
- q  out  DATA_WIDTH  show-ahead head word, valid while !empty.
- empty  out  1  FIFO holds 0 words.
- full  out  1  FIFO holds DEPTH words.
- almost_empty  out  1  usedw <= AE_THRESH.
- almost_full  out  1  usedw >= AF_THRESH.
- usedw  out  ADDR_WIDTH+1  words held, range 0..DEPTH, never wraps.
- hwm  out  ADDR_WIDTH+1  maximum usedw since reset, sclr or clr_hwm.
- clr_hwm  in  1  loads hwm with the current usedw.
- overflow  out  1  sticky: a write was rejected.
- underflow  out  1  sticky: a read was rejected.

Behaviour:
- Reset (nReset low, asynchronous):
  - Pointers, usedw and hwm = 0.
  - empty = 1, almost_empty = 1.
  - full = 0, almost_full = 0 (for AF_THRESH > 0).
  - overflow = 0, underflow = 0.
  - q = undefined while empty; the bench must not check it.
  - Memory contents are not reset.
- sclr has the same effect as reset on the next edge and takes priority over wrreq/rdreq in that cycle.
- Accept rules, evaluated on the pre-edge state:
  - rd_ok = rdreq & !empty.
  - wr_ok = wrreq & (!full | rd_ok). A write into a full FIFO is accepted only when a read is accepted in the same cycle.
- Rejected accesses:
  - wrreq & !wr_ok: no state change except overflow <= 1.
  - rdreq & !rd_ok: no state change except underflow <= 1.
  - Both sticky flags clear only on reset or sclr.
- Pointers are ADDR_WIDTH bits and wrap modulo DEPTH; usedw is kept as a separate counter.
  - usedw <= usedw + wr_ok - rd_ok.
  - Simultaneous accepted read and write: usedw unchanged.
- Status flags (empty, full, almost_*) are registered and derived from the next-state usedw, so they are correct in the cycle after the edge. No combinational path from wrreq/rdreq to any flag.
- Show-ahead data path:
  - q = mem[rd_ptr]; asynchronous read from the register array (or a RAM with bypass).
  - Write latency: a word written into an empty FIFO appears on q, with empty = 0, one cycle after the write edge.
  - Read latency: after an accepted read, q shows the next word one cycle later.
  - Empty with simultaneous write and read: the read is rejected (underflow set) and the write is accepted.
- hwm:
  - Each cycle, hwm <= max(hwm, next usedw).
  - clr_hwm: hwm <= next usedw.
  - sclr has priority over clr_hwm.
- Elaboration-time check: AE_THRESH < AF_THRESH <= DEPTH.

Test Plan (DATA_WIDTH=16, ADDR_WIDTH=4, DEPTH=16, AF_THRESH=12, AE_THRESH=2):
1. Hold nReset low 5 cycles, release, write 0xA5A5 once.
   - After reset: empty=1, usedw=0.
   - One cycle after the write: empty=0, q=0xA5A5, usedw=1, almost_empty=1.
   - Pulse rdreq: empty=1, usedw=0.
2. Write 0..15 back-to-back, then a 17th write of 0xDEAD.
   - full=1 at usedw=16; almost_full first high at usedw=12; overflow=1; usedw stays 16; hwm=16.
   - Read all 16 words: q sequence 0..15, then empty=1.
   - Total writes exceed 16, so pointers wrap; data stays correct.
3. FIFO full, assert wrreq=1 and rdreq=1 with data=0x0100.
   - usedw stays 16; overflow stays 0.
   - Drain: q sequence 1..15, then 0x0100.
4. Empty FIFO, assert rdreq=1 and wrreq=1 with data=0x0042.
   - underflow=1, usedw=1, q=0x0042.
   - Pulse sclr: usedw=0, empty=1, underflow=0, overflow=0, hwm=0.
5. Write 10 words, read 7, pulse clr_hwm, write 1.
   - hwm=10 before clr_hwm.
   - After clr_hwm: hwm=3, then 4 after the final write.
   - almost_empty toggles exactly at usedw 2 and 3.
6. Write 8 words, deassert nReset mid-stream for 1 cycle.
   - All outputs immediately return to reset values; the subsequent write/read of 0x1234 works normally.
